// File: rtl/three_parallel_crc_check.sv
// three_parallel_crc_check
//   Receive-side CRC checker. It takes a serial codeword (message followed by
//   its appended CRC), three bits per clock, MSB-first. It divides the
//   codeword by the generator with a 3-step unrolled LFSR. At the end of each
//   frame it presents the syndrome and a pass flag on a held result handshake.
//
// Parameters
//   CRC_W  generator degree / syndrome width
//   POLY   generator polynomial without the implicit x^CRC_W term
//   INIT   remainder value at reset and at each frame start
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   / in_ready   input beat handshake
//   in_data    3 codeword bits, in_data[2] earliest
//   in_last    final beat of the frame
//   in_nbits   valid bits on the last beat (1..3, 0 means 3)
//   chk_valid  / chk_ready  result handshake
//   chk_ok     syndrome is zero (and, optionally, the frame is long enough)
//   chk_rem    final remainder (syndrome)
//
// Build option
//   CRC_CHK_MINLEN_EN  adds a 16-bit saturating bit counter. Frames shorter
//                      than CRC_W+1 bits are reported as failed.
//
// States
//   ACCUM | accepting beats, remainder accumulating
//   DONE  | result held until the consumer takes it

module three_parallel_crc_check #(
  parameter int unsigned      CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_data,
  input  logic             in_last,
  input  logic [1:0]       in_nbits,
  output logic             chk_valid,
  input  logic             chk_ready,
  output logic             chk_ok,
  output logic [CRC_W-1:0] chk_rem
);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t           state;
  logic [CRC_W-1:0] rem;
  logic [CRC_W-1:0] rem1, rem2, rem3, rem_next;
  logic [1:0]       nsteps;
  logic             len_ok;
  logic             beat;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                input logic b);
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // Three serial steps chained in one cycle; a short last beat taps early.
  assign rem1 = crc_step(rem,  in_data[2]);
  assign rem2 = crc_step(rem1, in_data[1]);
  assign rem3 = crc_step(rem2, in_data[0]);

  always_comb begin
    nsteps = 2'd3;
    if (in_last && (in_nbits != 2'd0)) nsteps = in_nbits;
    case (nsteps)
      2'd1:    rem_next = rem1;
      2'd2:    rem_next = rem2;
      default: rem_next = rem3;
    endcase
  end

  assign in_ready  = (state == ACCUM);
  assign chk_valid = (state == DONE);
  assign beat      = in_valid && in_ready;

`ifdef CRC_CHK_MINLEN_EN
  logic [15:0] bit_cnt;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_next;

  // The length includes the bits of the beat being accepted.
  assign cnt_sum  = {1'b0, bit_cnt} + {15'd0, nsteps};
  assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  assign len_ok   = (cnt_next >= 16'(CRC_W + 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (beat) begin
      bit_cnt <= in_last ? 16'd0 : cnt_next;
    end
  end
`else
  assign len_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ACCUM;
      rem     <= INIT;
      chk_ok  <= 1'b0;
      chk_rem <= '0;
    end else if (state == ACCUM) begin
      if (in_valid) begin
        if (in_last) begin
          chk_rem <= rem_next;
          chk_ok  <= (rem_next == '0) && len_ok;
          rem     <= INIT;
          state   <= DONE;
        end else begin
          rem <= rem_next;
        end
      end
    end else begin
      if (chk_ready) state <= ACCUM;
    end
  end

endmodule
